// File: rtl/kclmul32_seq.sv
// 32x32 -> 64-bit carryless multiplier, Karatsuba halves through one shared kclmul16.
// Latency: 5 cycles from the accept edge to out_valid; one operand pair in flight.
// Backpressure: result held in DONE while out_ready is low; in_ready low until handshake.

// 16x16 -> 32-bit carryless multiplier with unconditional input registers.
module kclmul16 (
  input  logic        clk,
  input  logic [15:0] a_i,
  input  logic [15:0] b_i,
  output logic [31:0] p_o
);

  logic [15:0] a_q;
  logic [15:0] b_q;

  // Operand registers; the product of what was driven appears the next cycle.
  always_ff @(posedge clk) begin
    a_q <= a_i;
    b_q <= b_i;
  end

  // Shift-and-XOR product of the registered operands.
  always_comb begin
    logic [31:0] acc;
    acc = '0;
    for (int i = 0; i < 16; i++) begin
      if (b_q[i]) begin
        acc = acc ^ ({16'b0, a_q} << i);
      end
    end
    p_o = acc;
  end

endmodule

module kclmul32_seq #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      x,
  input  logic [31:0]      y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [63:0]      z,
  output logic             busy,
  output logic [CNT_W-1:0] op_count
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ISS_LO  = 3'd1,
    ISS_HI  = 3'd2,
    ISS_MID = 3'd3,
    CAP_MID = 3'd4,
    DONE    = 3'd5
  } state_t;

  state_t            state_q;
  state_t            state_d;

  logic [31:0]       xr_q;
  logic [31:0]       yr_q;
  logic [31:0]       p_lo_q;
  logic [31:0]       p_hi_q;
  logic [63:0]       z_q;
  logic [63:0]       z_d;
  logic              out_valid_q;
  logic [CNT_W-1:0]  op_count_q;

  logic [15:0]       xl, xh, xm;
  logic [15:0]       yl, yh, ym;
  logic [15:0]       mul_a;
  logic [15:0]       mul_b;
  logic [31:0]       mul_p;
  logic              accept;
  logic              deliver;

  assign xl = xr_q[15:0];
  assign xh = xr_q[31:16];
  assign xm = xl ^ xh;
  assign yl = yr_q[15:0];
  assign yh = yr_q[31:16];
  assign ym = yl ^ yh;

  kclmul16 u_mul (
    .clk (clk),
    .a_i (mul_a),
    .b_i (mul_b),
    .p_o (mul_p)
  );

  // State register; reset wins over any handshake in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: fixed issue sequence, then wait in DONE for the consumer.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_d = ISS_LO;
      ISS_LO:  state_d = ISS_HI;
      ISS_HI:  state_d = ISS_MID;
      ISS_MID: state_d = CAP_MID;
      CAP_MID: state_d = DONE;
      DONE: begin
        if (out_ready) begin
          state_d = in_valid ? ISS_LO : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs from state: ready/busy flags and the shared multiplier operand mux.
  always_comb begin
    in_ready = 1'b0;
    busy     = 1'b1;
    mul_a    = '0;
    mul_b    = '0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
      end
      ISS_LO: begin
        mul_a = xl;
        mul_b = yl;
      end
      ISS_HI: begin
        mul_a = xh;
        mul_b = yh;
      end
      ISS_MID: begin
        mul_a = xm;
        mul_b = ym;
      end
      DONE:    in_ready = out_ready;
      default: ;
    endcase
  end

  assign accept  = in_valid & in_ready;
  assign deliver = out_valid_q & out_ready;

  // Karatsuba recombination; in CAP_MID the multiplier output is the mid product.
  always_comb begin
    z_d = {p_hi_q, p_lo_q} ^ {16'b0, (p_lo_q ^ p_hi_q ^ mul_p), 16'b0};
  end

  // Datapath: operand capture, partial-product capture, result and counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      xr_q        <= '0;
      yr_q        <= '0;
      p_lo_q      <= '0;
      p_hi_q      <= '0;
      z_q         <= '0;
      out_valid_q <= 1'b0;
      op_count_q  <= '0;
    end else begin
      if (accept) begin
        xr_q <= x;
        yr_q <= y;
      end
      if (state_q == ISS_HI) begin
        p_lo_q <= mul_p;
      end
      if (state_q == ISS_MID) begin
        p_hi_q <= mul_p;
      end
      if (state_q == CAP_MID) begin
        z_q         <= z_d;
        out_valid_q <= 1'b1;
      end
      if (deliver) begin
        out_valid_q <= 1'b0;
        op_count_q  <= op_count_q + CNT_W'(1);
      end
    end
  end

  assign out_valid = out_valid_q;
  assign z         = z_q;
  assign op_count  = op_count_q;

endmodule

// File: tb/tb_kclmul32_seq.sv
// Self-checking bench for kclmul32_seq against a bit-serial carryless reference.
// Directed products, back-to-back with stall, reset mid-operation, counter wrap.
module tb_kclmul32_seq;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] x;
  logic [31:0] y;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] z;
  logic        busy;
  logic [1:0]  op_count;

  int checks   = 0;
  int failures = 0;
  int done_cnt = 0;

  kclmul32_seq #(.CNT_W(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x         (x),
    .y         (y),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .z         (z),
    .busy      (busy),
    .op_count  (op_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] clmul_ref(input logic [31:0] a, input logic [31:0] b);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < 32; i++) begin
      if (b[i]) r = r ^ (64'(a) << i);
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One isolated product: accept, check latency and result, then handshake.
  task automatic run_op(input logic [31:0] xx, input logic [31:0] yy, input logic [63:0] exp);
    int lat;
    out_ready = 1'b1;
    x = xx;
    y = yy;
    in_valid = 1'b1;
    #1;
    chk("in_ready_before_accept", 64'(in_ready), 64'd1);
    step();
    in_valid = 1'b0;
    x = $urandom;
    y = $urandom;
    lat = 1;
    while (!out_valid && lat < 20) begin
      step();
      x = $urandom;
      y = $urandom;
      lat++;
    end
    chk("latency", 64'(lat), 64'd5);
    chk("out_valid", 64'(out_valid), 64'd1);
    chk("z", z, exp);
    step();
    done_cnt++;
    chk("op_count", 64'(op_count), 64'(done_cnt % 4));
    chk("out_valid_after_hs", 64'(out_valid), 64'd0);
    chk("busy_after_hs", 64'(busy), 64'd0);
  endtask

  logic [31:0] px [4];
  logic [31:0] py [4];
  logic [63:0] pz [4];
  int          sent;
  int          got;
  int          stall;
  logic        hs_in;
  logic        hs_out;

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    x = '0;
    y = '0;
    step();
    step();
    rst = 1'b0;
    step();
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_z", z, 64'd0);
    chk("rst_op_count", 64'(op_count), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    step();
    chk("idle_busy", 64'(busy), 64'd0);

    // Directed products
    run_op(32'h0000_0003, 32'h0000_0003, 64'h0000_0000_0000_0005);
    run_op(32'hFFFF_FFFF, 32'h0000_0001, 64'h0000_0000_FFFF_FFFF);
    run_op(32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000);
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h5555_5555_5555_5555);
    run_op(32'h1234_5678, 32'h9ABC_DEF0, clmul_ref(32'h1234_5678, 32'h9ABC_DEF0));

    // Back-to-back with in_valid held, 3-cycle stall on the second result
    for (int i = 0; i < 4; i++) begin
      px[i] = $urandom;
      py[i] = $urandom;
      pz[i] = clmul_ref(px[i], py[i]);
    end
    sent = 0;
    got = 0;
    stall = 0;
    x = px[0];
    y = py[0];
    in_valid = 1'b1;
    for (int cyc = 0; cyc < 200 && got < 4; cyc++) begin
      if (out_valid && got == 1 && stall < 3) out_ready = 1'b0;
      else out_ready = 1'b1;
      #1;
      if (!out_ready) begin
        chk("stall_out_valid", 64'(out_valid), 64'd1);
        chk("stall_z", z, pz[1]);
        chk("stall_in_ready", 64'(in_ready), 64'd0);
        stall++;
      end
      hs_in  = in_valid && in_ready;
      hs_out = out_valid && out_ready;
      if (hs_out) begin
        chk("b2b_z", z, pz[got]);
        if (sent < 4) chk("b2b_accept_on_hs", 64'(hs_in), 64'd1);
        got++;
        done_cnt++;
      end
      step();
      if (hs_in) begin
        sent++;
        if (sent < 4) begin
          x = px[sent];
          y = py[sent];
        end else begin
          in_valid = 1'b0;
          x = $urandom;
          y = $urandom;
        end
      end
      if (hs_out) chk("b2b_op_count", 64'(op_count), 64'(done_cnt % 4));
    end
    chk("b2b_results", 64'(got), 64'd4);
    chk("b2b_stall_cycles", 64'(stall), 64'd3);
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    chk("b2b_idle", 64'(busy), 64'd0);

    // Reset in cycle 3 of an operation
    x = 32'hFFFF_FFFF;
    y = 32'hFFFF_FFFF;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_z", z, 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_op_count", 64'(op_count), 64'd0);
    done_cnt = 0;
    run_op(32'h0000_0002, 32'h0000_0003, 64'h0000_0000_0000_0006);

    // Counter wrap at 2 bits, random operands
    rst = 1'b1;
    step();
    rst = 1'b0;
    done_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      logic [31:0] a;
      logic [31:0] b;
      a = $urandom;
      b = $urandom;
      run_op(a, b, clmul_ref(a, b));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
